// File: rtl/mmio_uart_tx_if.sv
// MMIO bus bundle between the MMU/core and the UART transmitter.
// sel is the MMU's MMIOEnable strobe; readData is returned combinationally.
interface mmio_uart_tx_if;
  logic        sel;
  logic        we;
  logic [15:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;

  modport master (output sel, we, address, writeData, input readData);
  modport slave  (input sel, we, address, writeData, output readData);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter.
// CPU stores feed a small TX FIFO that a baud-rate FSM drains onto the tx pin.
module mmio_uart_tx #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic           clk,
  input  logic           reset,
  mmio_uart_tx_if.slave  bus,
  output logic           tx,
  output logic           busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;

  logic [7:0]       fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      div_q, div_d;
  logic [1:0]       state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [15:0]      baud_cnt_q, baud_cnt_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;

  logic        wr_en;
  logic [1:0]  reg_sel;
  logic        fifo_full, fifo_empty;
  logic        push, pop;
  logic [15:0] bit_load;
  logic        unused_bits;

  assign wr_en      = bus.sel && bus.we;
  assign reg_sel    = bus.address[3:2];
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  // Full is judged on the pre-edge count, so a same-cycle pop never rescues a write.
  assign push       = wr_en && (reg_sel == REG_TXDATA) && !fifo_full;
  // A divisor of 0 behaves as 1: the per-bit count is reloaded with div-1.
  assign bit_load   = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
  assign unused_bits = ^{bus.address[15:4], bus.address[1:0], bus.writeData[31:16]};

  // Baud FSM: next state, pop request and serial output.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    baud_cnt_d = baud_cnt_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = fifo_q[rd_ptr_q];
          baud_cnt_d = bit_load;
          state_d    = ST_START;
        end
      end
      default: begin
        if (baud_cnt_q != 16'd0) begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end else begin
          baud_cnt_d = bit_load;
          case (state_q)
            ST_START: begin
              state_d   = ST_DATA;
              bit_idx_d = 3'd0;
            end
            ST_DATA: begin
              if (bit_idx_q == 3'd7) state_d = ST_STOP;
              else                   bit_idx_d = bit_idx_q + 3'd1;
            end
            default: begin
              if (!fifo_empty) begin
                pop     = 1'b1;
                shift_d = fifo_q[rd_ptr_q];
                state_d = ST_START;
              end else begin
                state_d = ST_IDLE;
              end
            end
          endcase
        end
      end
    endcase

    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[bit_idx_d];
      default:  tx_d = 1'b1;
    endcase
  end

  // FIFO pointers/count and the writable registers.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    div_d    = div_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (wr_en && (reg_sel == REG_STATUS) && bus.writeData[3]) ovf_d = 1'b0;
    if (wr_en && (reg_sel == REG_TXDATA) && fifo_full)        ovf_d = 1'b1;
    if (wr_en && (reg_sel == REG_BAUDDIV)) div_d = bus.writeData[15:0];
    busy_d = (state_d != ST_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= 8'd0;
      bit_idx_q  <= 3'd0;
      baud_cnt_q <= 16'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      div_q      <= DEFAULT_DIV;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      baud_cnt_q <= baud_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      div_q      <= div_d;
    end
  end

  // FIFO storage needs no reset; the count decides validity.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= bus.writeData[7:0];
  end

  // Combinational load path for the single-cycle core.
  always_comb begin
    bus.readData = 32'd0;
    if (bus.sel) begin
      case (reg_sel)
        REG_STATUS:  bus.readData = {28'd0, ovf_q, (state_q != ST_IDLE), fifo_empty, fifo_full};
        REG_BAUDDIV: bus.readData = {16'd0, div_q};
        default:     bus.readData = 32'd0;
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: a timeline model predicts frame start edges,
// per-bit durations and FIFO occupancy; a line monitor decodes tx and checks each frame.
module tb_mmio_uart_tx;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx, busy;
  mmio_uart_tx_if bus();

  mmio_uart_tx #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd868)) dut (
    .clk(clk), .reset(reset), .bus(bus), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int total = 0;
  int bad   = 0;

  // Model: accepted bytes with their push edge, divisor write history.
  int          fr_t[$];
  logic [7:0]  fr_d[$];
  int          fs[$];
  int          fe[$];
  int          hw[$];
  int          hv[$];
  logic        m_ovf;
  logic        mon_hold = 1'b0;

  typedef struct { int idx; logic [7:0] data; } exp_t;
  exp_t sb[$];

  // Divisor used for a bit whose count is loaded at edge e (writes before e only).
  function automatic int div_at(input int e);
    int v;
    v = 868;
    for (int k = 0; k < hw.size(); k++) if (hw[k] < e) v = hv[k];
    return (v == 0) ? 1 : v;
  endfunction

  function automatic void model_reset();
    fr_t.delete(); fr_d.delete(); hw.delete(); hv.delete(); sb.delete();
    hw.push_back(-1); hv.push_back(868);
    m_ovf = 1'b0;
  endfunction

  // Frame i starts one edge after its push or when the previous frame ends, whichever is later.
  function automatic void compute_sched();
    int s, e;
    fs.delete(); fe.delete();
    for (int i = 0; i < fr_t.size(); i++) begin
      s = fr_t[i] + 1;
      if (i > 0 && fe[i-1] > s) s = fe[i-1];
      e = s;
      for (int b = 0; b < 10; b++) e += div_at(e);
      fs.push_back(s);
      fe.push_back(e);
    end
  endfunction

  // FIFO occupancy just before edge w.
  function automatic int cnt_before(input int w);
    int c;
    c = 0;
    for (int i = 0; i < fr_t.size(); i++) if (fr_t[i] < w && fs[i] >= w) c++;
    return c;
  endfunction

  function automatic bit active_after(input int n);
    for (int i = 0; i < fr_t.size(); i++) if (fs[i] <= n && n < fe[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_busy(input int n);
    compute_sched();
    return (cnt_before(n + 1) != 0) || active_after(n);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    int w;
    @(negedge clk);
    w = edge_n + 1;
    bus.sel = 1'b1; bus.we = 1'b1;
    bus.address = {12'h0, a, 2'b00};
    bus.writeData = d;
    case (a)
      2'd0: begin
        compute_sched();
        if (cnt_before(w) >= DEPTH) m_ovf = 1'b1;
        else begin
          fr_t.push_back(w);
          fr_d.push_back(d[7:0]);
          sb.push_back('{idx: fr_t.size() - 1, data: d[7:0]});
        end
      end
      2'd1: if (d[3]) m_ovf = 1'b0;
      2'd2: begin hw.push_back(w); hv.push_back(int'(d[15:0])); end
      default: ;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.sel = 1'b0; bus.we = 1'b0;
    end
  endtask

  task automatic rd(input logic [1:0] a, input string name);
    int n, c;
    bit act;
    logic [31:0] e;
    @(negedge clk);
    bus.sel = 1'b1; bus.we = 1'b0;
    bus.address = {12'h0, a, 2'b00};
    n = edge_n;
    #1;
    compute_sched();
    c   = cnt_before(n + 1);
    act = active_after(n);
    case (a)
      2'd1:    e = {28'd0, m_ovf, act, (c == 0), (c == DEPTH)};
      2'd2:    e = {16'd0, 16'(hv[hv.size()-1])};
      default: e = 32'd0;
    endcase
    chk(name, bus.readData, e);
    chk({name, "_busy"}, {31'd0, busy}, {31'd0, act || (c != 0)});
    if (!act) chk({name, "_tx_idle"}, {31'd0, tx}, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 mon_hold = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    bus.sel = 1'b0; bus.we = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mon_hold = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (k < 5000 && (sb.size() != 0 || model_busy(edge_n))) begin
      @(negedge clk);
      bus.sel = 1'b0; bus.we = 1'b0;
      k++;
    end
    total++;
    if (k >= 5000) begin
      bad++;
      $display("FAIL drain_%s: still busy after %0d cycles, required idle", name, k);
    end
  endtask

  // Monitor: decode one frame starting at the current negedge.
  task automatic mon_frame();
    exp_t e;
    int d, errs, k;
    logic exp_bit;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_frame: start bit at edge %0d, required none", edge_n);
      k = 0;
      while (tx === 1'b0 && k < 10000) begin @(negedge clk); k++; end
      return;
    end
    e = sb.pop_front();
    compute_sched();
    if (e.idx >= fs.size()) return;
    chk("frame_start_edge", edge_n, fs[e.idx]);
    for (int b = 0; b < 10; b++) begin
      if (b > 0) @(negedge clk);
      if (reset || mon_hold) return;
      exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e.data[b-1];
      d = div_at(edge_n);
      errs = (tx !== exp_bit) ? 1 : 0;
      for (int c = 1; c < d; c++) begin
        @(negedge clk);
        if (reset || mon_hold) return;
        if (tx !== exp_bit) errs++;
      end
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL frame_bit%0d byte=%h: %0d of %0d cycles wrong, required tx=%b", b, e.data, errs, d, exp_bit);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset || mon_hold) continue;
      if (tx === 1'b0) mon_frame();
    end
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int p, k, i;
    bus.sel = 1'b0; bus.we = 1'b0; bus.address = 16'd0; bus.writeData = 32'd0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state and register map.
    rd(2'd1, "status_reset");
    rd(2'd2, "bauddiv_reset");
    rd(2'd0, "txdata_read");
    rd(2'd3, "reserved_read");
    @(negedge clk);
    bus.sel = 1'b0; bus.address = 16'h0004;
    #1 chk("readdata_sel0", bus.readData, 32'd0);

    // Single frame at div 4.
    wr(2'd2, 32'd4);
    wr(2'd0, 32'hA5);
    rd(2'd1, "status_a5_busy");
    drain("a5");
    rd(2'd1, "status_a5_done");

    // Four back-to-back frames at div 2.
    wr(2'd2, 32'd2);
    for (int j = 1; j <= 4; j++) wr(2'd0, 32'(j));
    drain("four");
    rd(2'd1, "status_four_done");

    // Overflow: six back-to-back writes, then clear.
    for (int j = 0; j < 6; j++) wr(2'd0, 32'h10 + 32'(j));
    rd(2'd1, "status_overflow");
    wr(2'd1, 32'h8);
    rd(2'd1, "status_ovf_cleared");
    drain("ovf");

    // Reset during data bit 3 with two bytes still queued.
    wr(2'd2, 32'd4);
    wr(2'd0, 32'hC3);
    wr(2'd0, 32'h3C);
    wr(2'd0, 32'h77);
    idle(1);
    compute_sched();
    i = fr_t.size() - 3;
    p = fs[i] + 17;
    k = 0;
    while (edge_n < p && k < 1000) begin @(negedge clk); k++; end
    chk("reach_bit3", {31'd0, (k < 1000)}, 32'd1);
    do_reset();
    rd(2'd1, "status_after_midreset");
    idle(200);
    rd(2'd1, "status_quiet");

    // Divisor 0 behaves as 1.
    wr(2'd2, 32'd0);
    wr(2'd0, 32'h5A);
    drain("div0");
    rd(2'd2, "bauddiv_zero");

    // Divisor change in the middle of a bit.
    wr(2'd2, 32'd2);
    wr(2'd0, 32'h96);
    idle(1);
    compute_sched();
    p = fs[fr_t.size() - 1] + 3;
    k = 0;
    while (edge_n < p && k < 1000) begin @(negedge clk); k++; end
    wr(2'd2, 32'd6);
    drain("divchange");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 10))
        0, 1, 2, 3, 4: wr(2'd0, $urandom);
        5:  wr(2'd2, 32'($urandom_range(0, 4)));
        6:  wr(2'd1, $urandom);
        7:  rd(2'($urandom_range(0, 3)), "rand_read");
        8:  idle($urandom_range(1, 20));
        9:  wr(2'd3, $urandom);
        default: if ($urandom_range(0, 9) == 0) do_reset(); else idle(1);
      endcase
    end
    drain("random");
    rd(2'd1, "status_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
